uart_rx_fifo_feeder: RTL

//   Serial receiver that sits directly upstream of the receive fifo: samples the rx line

---
 rtl/uart_rx_fifo_feeder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo_feeder.sv
// UART receiver feeding a write-only fifo port.
// Uses 16x oversampling with s_tick and delivers each word on dout/rx_done_tick.
// Flags framing errors, and flags overrun when a word arrives while the fifo is full.
// Optional even parity is enabled with the UART_RX_PARITY_EN macro.
module uart_rx_fifo_feeder #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned SB_TICK   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 s_tick,
    input  logic                 fifo_full,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned SW = 5;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t               state, state_n;
    logic                 rx_meta, rx_s;
    logic [SW-1:0]        s_cnt, s_cnt_n;
    logic [NW-1:0]        n_cnt, n_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 deliver_c;
    logic [DATA_BITS-1:0] dout_n;
    logic                 frame_err_n;
    logic                 overrun_n;
`ifdef UART_RX_PARITY_EN
    logic                 p_bit, p_bit_n;
    logic                 parity_err_n;
`endif

    // Two-flop synchronizer for the asynchronous rx line (idle high).
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM and datapath state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s_cnt <= '0;
            n_cnt <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            p_bit <= 1'b0;
`endif
        end else begin
            state <= state_n;
            s_cnt <= s_cnt_n;
            n_cnt <= n_cnt_n;
            shreg <= shreg_n;
`ifdef UART_RX_PARITY_EN
            p_bit <= p_bit_n;
`endif
        end
    end

    // Next-state logic: all counting advances only on s_tick, except the IDLE start detection.
    always_comb begin
        state_n   = state;
        s_cnt_n   = s_cnt;
        n_cnt_n   = n_cnt;
        shreg_n   = shreg;
        deliver_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        p_bit_n   = p_bit;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt == SW'(7)) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_cnt_n = '0;
                            n_cnt_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt == SW'(15)) begin
                        s_cnt_n = '0;
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        if (n_cnt == NW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            n_cnt_n = n_cnt + NW'(1);
                        end
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt == SW'(15)) begin
                        p_bit_n = rx_s;
                        state_n = STOP;
                        s_cnt_n = '0;
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt == SW'(SB_TICK - 1)) begin
                        state_n   = IDLE;
                        deliver_c = 1'b1;
                    end else begin
                        s_cnt_n = s_cnt + SW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output next-values: capture the word and its flags on delivery; overrun is sticky, set wins over clear.
    always_comb begin
        dout_n      = dout;
        frame_err_n = frame_err;
        overrun_n   = overrun_err;
`ifdef UART_RX_PARITY_EN
        parity_err_n = parity_err;
`endif
        if (deliver_c) begin
            dout_n      = shreg;
            frame_err_n = ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err_n = ^{shreg, p_bit};
`endif
        end
        if (clr_err) begin
            overrun_n = 1'b0;
        end
        if (rx_done_tick && fifo_full) begin
            overrun_n = 1'b1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            dout         <= dout_n;
            rx_done_tick <= deliver_c;
            frame_err    <= frame_err_n;
            overrun_err  <= overrun_n;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity flag register, present only when parity checking is built in.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_err_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
